reg_bank_issue: RTL and testbench
=================================

Name: reg_bank_issue

Overview:
- Register bank plus issue sequencer that feeds the combinational ALU: reads two source registers, drives OP_1/OP_2/ALU_Sel, captures Result, writes it back to a destination register.
- Acts as the producer and consumer of the ALU interface. Sits beside the ALU in the datapath of the banco_de_registros block.
- Accepts one operation at a time over a valid/ready handshake; 3 cycles per operation.

Parameters:
- NREGS, 32, number of 32-bit registers; must be a power of 2.
- AW, 5, register address width; must equal log2(NREGS).

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- INSTR_VALID  in  1  operation request.
- INSTR_READY  out  1  high when able to accept an operation.
- RS1  in  AW  source register A.
- RS2  in  AW  source register B.
- RD  in  AW  destination register.
- SEL  in  3  ALU operation code, passed to ALU_Sel unchanged.
- OP_1  out  32  operand A to ALU (registered).
- OP_2  out  32  operand B to ALU (registered).
- ALU_Sel  out  3  operation select to ALU (registered).
- Result  in  32  ALU result (combinational from OP_1/OP_2/ALU_Sel).
- DONE  out  1  one-cycle pulse when write-back occurs.
- EXT_WE  in  1  external preload write enable.
- EXT_ADDR  in  AW  preload address.
- EXT_WDATA  in  32  preload data.
- DBG_ADDR  in  AW  debug read address.
- DBG_DATA  out  32  combinational read of reg[DBG_ADDR].

Behaviour:
- Reset (RST=1 at edge): all registers 0, OP_1=0, OP_2=0, ALU_Sel=0, DONE=0, FSM in IDLE. Any in-flight operation is aborted with no write-back.
- INSTR_READY = (state==IDLE), combinational. It is high during RST.
- FSM states IDLE, EXEC, WB:
  - IDLE: on INSTR_VALID & INSTR_READY, latch OP_1<=reg[RS1], OP_2<=reg[RS2], ALU_Sel<=SEL, rd_q<=RD; go to EXEC. Otherwise stay.
  - EXEC: OP_1/OP_2/ALU_Sel are held stable. At the edge, capture res_q<=Result; go to WB.
  - WB: reg[rd_q]<=res_q; DONE=1 for exactly this cycle; go to IDLE.
- Latency: accept at edge N, Result sampled at edge N+1, register written at edge N+2 (DONE high in the cycle before N+2). Next accept is possible at edge N+3.
- Read-after-write: the write lands before the next accept, so no forwarding is needed. A back-to-back op reading the previous RD sees the new value.
- OP_1/OP_2/ALU_Sel keep their last values in IDLE; they are not cleared after an op.
- RS1==RS2 is legal; both operands get the same value.
- ALU_Sel codes 101..111 pass through unchanged; the written value is whatever the ALU returns (0).
- EXT_WE: writes reg[EXT_ADDR]<=EXT_WDATA in any state.
  - If the cycle is WB and EXT_ADDR==rd_q, the WB write wins.
  - A preload in the accept cycle is not visible to that accept; the read uses the pre-edge value.
- DBG_DATA: combinational read of the current register contents. No bypass of same-cycle writes.
- All arithmetic is inside the ALU; this block performs none. Results are 32-bit; overflow is whatever the ALU produces.

Optional Feature:
- Macro R0_ZERO_EN.
  - Defined: reg[0] always reads 0 on operand reads and DBG_DATA. WB and EXT writes to address 0 are discarded, but DONE still pulses.
  - Undefined: reg[0] is an ordinary register.

Decomposition:
- Shared package reg_bank_pkg:
  - ALU op constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b011, ALU_GT=3'b100.
  - FSM state encoding IDLE/EXEC/WB.
  - Default NREGS/AW.
- One sub-module, reg_file_2r2w: storage with two async read ports, a debug read port, and a prioritised WB/EXT write. reg_bank_issue holds the FSM and operand/result registers.

Test Plan:
- Preload r1=5, r2=3 via EXT; op SEL=010 RS1=1 RS2=2 RD=4 -> OP_1=5, OP_2=3 in EXEC; DONE 2 cycles after accept; r4 reads 8.
- Back-to-back: SUB r5=r4-r2 issued as soon as INSTR_READY rises -> r5=5; INSTR_READY low for exactly 2 cycles per op.
- GT with r1=5, r2=3 -> 1; swapped operands -> 0; SEL=111 -> RD written 0.
- WB and EXT_WE hit the same address in the same cycle, with EXT_WDATA=0xDEAD -> register holds the ALU result. A different address -> both writes land.
- RST asserted during EXEC -> no write, DONE stays 0, all registers 0, INSTR_READY=1 on the next cycle.
- With R0_ZERO_EN: ADD RD=0 of 7+7 -> DBG_DATA at address 0 =0 and DONE pulses. Without it -> reads 14.

Source files
------------

// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module : reg_bank_pkg
// Brief  : Shared ALU op codes, issue FSM encoding and default bank geometry.
// Rev    : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

    localparam int c_DEF_NREGS = 32;
    localparam int c_DEF_AW    = 5;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_GT  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_bank_issue_if.sv
`default_nettype none
// ============================================================================
// Module : reg_bank_issue_if
// Brief  : Instruction issue handshake and write-back completion pulse.
// Rev    : 1.0 - initial release
// ============================================================================
interface reg_bank_issue_if
    import reg_bank_pkg::*;
#(
    parameter int AW = c_DEF_AW
);
    logic          INSTR_VALID;
    logic          INSTR_READY;
    logic [AW-1:0] RS1;
    logic [AW-1:0] RS2;
    logic [AW-1:0] RD;
    logic [2:0]    SEL;
    logic          DONE;

    modport master (
        output INSTR_VALID, RS1, RS2, RD, SEL,
        input  INSTR_READY, DONE
    );

    modport slave (
        input  INSTR_VALID, RS1, RS2, RD, SEL,
        output INSTR_READY, DONE
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_2r2w.sv
`default_nettype none
// ============================================================================
// Module : reg_file_2r2w
// Brief  : Register storage, two operand reads, a debug read, WB-over-EXT write.
//          Build macro R0_ZERO_EN hard-wires register 0 to zero.
// Rev    : 1.0 - initial release
// ============================================================================
module reg_file_2r2w
    import reg_bank_pkg::*;
#(
    parameter int NREGS = c_DEF_NREGS,
    parameter int AW    = c_DEF_AW
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    input  wire logic [AW-1:0] i_rd_addr_a,
    output logic      [31:0]   o_rd_data_a,
    input  wire logic [AW-1:0] i_rd_addr_b,
    output logic      [31:0]   o_rd_data_b,
    input  wire logic [AW-1:0] i_dbg_addr,
    output logic      [31:0]   o_dbg_data,
    input  wire logic          i_wb_we,
    input  wire logic [AW-1:0] i_wb_addr,
    input  wire logic [31:0]   i_wb_data,
    input  wire logic          i_ext_we,
    input  wire logic [AW-1:0] i_ext_addr,
    input  wire logic [31:0]   i_ext_data
);

`ifdef R0_ZERO_EN
    localparam logic c_R0_ZERO = 1'b1;
`else
    localparam logic c_R0_ZERO = 1'b0;
`endif

    logic [31:0] r_mem [NREGS];
    logic        w_wb_ok;
    logic        w_ext_ok;

    function automatic logic [31:0] f_read(input logic [AW-1:0] addr,
                                           input logic [31:0]   data);
        return (c_R0_ZERO && (addr == '0)) ? 32'd0 : data;
    endfunction

    assign w_wb_ok  = i_wb_we  && !(c_R0_ZERO && (i_wb_addr  == '0));
    assign w_ext_ok = i_ext_we && !(c_R0_ZERO && (i_ext_addr == '0));

    // The WB assignment comes last so it overrides EXT on an address clash.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            if (w_ext_ok) begin
                r_mem[i_ext_addr] <= i_ext_data;
            end
            if (w_wb_ok) begin
                r_mem[i_wb_addr] <= i_wb_data;
            end
        end
    end

    assign o_rd_data_a = f_read(i_rd_addr_a, r_mem[i_rd_addr_a]);
    assign o_rd_data_b = f_read(i_rd_addr_b, r_mem[i_rd_addr_b]);
    assign o_dbg_data  = f_read(i_dbg_addr,  r_mem[i_dbg_addr]);

endmodule
`default_nettype wire

// File: rtl/reg_bank_issue.sv
`default_nettype none
// ============================================================================
// Module : reg_bank_issue
// Brief  : Issue sequencer driving an external combinational ALU and writing
//          its result back; 3 cycles per op. Optional macro: R0_ZERO_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module reg_bank_issue
    import reg_bank_pkg::*;
#(
    parameter int NREGS = c_DEF_NREGS,
    parameter int AW    = c_DEF_AW
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    reg_bank_issue_if.slave    bus,
    output logic      [31:0]   OP_1,
    output logic      [31:0]   OP_2,
    output logic      [2:0]    ALU_Sel,
    input  wire logic [31:0]   Result,
    input  wire logic          EXT_WE,
    input  wire logic [AW-1:0] EXT_ADDR,
    input  wire logic [31:0]   EXT_WDATA,
    input  wire logic [AW-1:0] DBG_ADDR,
    output logic      [31:0]   DBG_DATA
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_accept;
    logic          w_wb_we;
    logic [31:0]   r_op_1;
    logic [31:0]   r_op_2;
    logic [2:0]    r_alu_sel;
    logic [AW-1:0] r_rd_q;
    logic [31:0]   r_res_q;
    logic [31:0]   w_rs1_data;
    logic [31:0]   w_rs2_data;

    reg_file_2r2w #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_reg_file (
        .CLK         (CLK),
        .RST         (RST),
        .i_rd_addr_a (bus.RS1),
        .o_rd_data_a (w_rs1_data),
        .i_rd_addr_b (bus.RS2),
        .o_rd_data_b (w_rs2_data),
        .i_dbg_addr  (DBG_ADDR),
        .o_dbg_data  (DBG_DATA),
        .i_wb_we     (w_wb_we),
        .i_wb_addr   (r_rd_q),
        .i_wb_data   (r_res_q),
        .i_ext_we    (EXT_WE),
        .i_ext_addr  (EXT_ADDR),
        .i_ext_data  (EXT_WDATA)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_wb_we     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.INSTR_VALID) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = WB;
            end
            WB: begin
                w_wb_we     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.INSTR_READY = (r_state == IDLE);
    assign bus.DONE        = w_wb_we;

    // Operands stay put outside the accept cycle so the ALU output is stable
    // through EXEC and the last op stays visible while idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_op_1    <= 32'd0;
            r_op_2    <= 32'd0;
            r_alu_sel <= 3'd0;
            r_rd_q    <= '0;
            r_res_q   <= 32'd0;
        end else begin
            if (w_accept) begin
                r_op_1    <= w_rs1_data;
                r_op_2    <= w_rs2_data;
                r_alu_sel <= bus.SEL;
                r_rd_q    <= bus.RD;
            end
            if (r_state == EXEC) begin
                r_res_q <= Result;
            end
        end
    end

    assign OP_1    = r_op_1;
    assign OP_2    = r_op_2;
    assign ALU_Sel = r_alu_sel;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_issue.sv
`default_nettype none
// ============================================================================
// Module : tb_reg_bank_issue
// Brief  : Directed bench for reg_bank_issue with a behavioural ALU alongside.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_issue;
    import reg_bank_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] OP_1;
    logic [31:0] OP_2;
    logic [2:0]  ALU_Sel;
    logic [31:0] Result;
    logic        EXT_WE;
    logic [4:0]  EXT_ADDR;
    logic [31:0] EXT_WDATA;
    logic [4:0]  DBG_ADDR;
    logic [31:0] DBG_DATA;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 CLK = ~CLK;

    reg_bank_issue_if #(.AW(5)) u_bus ();

    reg_bank_issue #(
        .NREGS (32),
        .AW    (5)
    ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (u_bus.slave),
        .OP_1      (OP_1),
        .OP_2      (OP_2),
        .ALU_Sel   (ALU_Sel),
        .Result    (Result),
        .EXT_WE    (EXT_WE),
        .EXT_ADDR  (EXT_ADDR),
        .EXT_WDATA (EXT_WDATA),
        .DBG_ADDR  (DBG_ADDR),
        .DBG_DATA  (DBG_DATA)
    );

    // Combinational ALU the block talks to.
    always_comb begin
        Result = 32'd0;
        case (ALU_Sel)
            ALU_AND: Result = OP_1 & OP_2;
            ALU_OR:  Result = OP_1 | OP_2;
            ALU_ADD: Result = OP_1 + OP_2;
            ALU_SUB: Result = OP_1 - OP_2;
            ALU_GT:  Result = (OP_1 > OP_2) ? 32'd1 : 32'd0;
            default: Result = 32'd0;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [4:0] addr,
                             input logic [31:0] exp);
        DBG_ADDR = addr;
        #1;
        check_val(tag, DBG_DATA, exp);
    endtask

    task automatic ext_write(input logic [4:0] addr, input logic [31:0] data);
        EXT_WE    = 1'b1;
        EXT_ADDR  = addr;
        EXT_WDATA = data;
        @(negedge CLK);
        EXT_WE    = 1'b0;
    endtask

    // Returns at the negedge inside EXEC.
    task automatic issue(input logic [2:0] sel, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d);
        int n = 0;
        while (u_bus.INSTR_READY !== 1'b1 && n < 8) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 8) check_val("ready_timeout", 32'(u_bus.INSTR_READY), 32'd1);
        u_bus.INSTR_VALID = 1'b1;
        u_bus.SEL         = sel;
        u_bus.RS1         = a;
        u_bus.RS2         = b;
        u_bus.RD          = d;
        @(negedge CLK);
        u_bus.INSTR_VALID = 1'b0;
        check_val("exec_ready_low", 32'(u_bus.INSTR_READY), 32'd0);
        check_val("exec_done_low",  32'(u_bus.DONE),        32'd0);
    endtask

    // Walks WB and back to IDLE; optionally fires an EXT write during WB.
    task automatic wb_phase(input string tag, input logic ext_en,
                            input logic [4:0] ext_a, input logic [31:0] ext_d);
        @(negedge CLK);
        check_val({tag, "_done"},   32'(u_bus.DONE),        32'd1);
        check_val({tag, "_rdy_wb"}, 32'(u_bus.INSTR_READY), 32'd0);
        EXT_WE    = ext_en;
        EXT_ADDR  = ext_a;
        EXT_WDATA = ext_d;
        @(negedge CLK);
        EXT_WE = 1'b0;
        check_val({tag, "_done_clr"}, 32'(u_bus.DONE),        32'd0);
        check_val({tag, "_rdy_idle"}, 32'(u_bus.INSTR_READY), 32'd1);
    endtask

    initial begin
        RST               = 1'b1;
        EXT_WE            = 1'b0;
        EXT_ADDR          = '0;
        EXT_WDATA         = '0;
        DBG_ADDR          = '0;
        u_bus.INSTR_VALID = 1'b0;
        u_bus.SEL         = '0;
        u_bus.RS1         = '0;
        u_bus.RS2         = '0;
        u_bus.RD          = '0;

        repeat (2) @(negedge CLK);
        check_val("rst_ready",   32'(u_bus.INSTR_READY), 32'd1);
        check_val("rst_done",    32'(u_bus.DONE),        32'd0);
        check_val("rst_op1",     OP_1,                   32'd0);
        check_val("rst_op2",     OP_2,                   32'd0);
        check_val("rst_alu_sel", 32'(ALU_Sel),           32'd0);
        check_reg("rst_r1", 5'd1, 32'd0);
        RST = 1'b0;

        ext_write(5'd1, 32'd5);
        ext_write(5'd2, 32'd3);
        ext_write(5'd3, 32'd7);
        ext_write(5'd7, 32'h55);
        ext_write(5'd8, 32'h77);
        check_reg("pre_r1", 5'd1, 32'd5);
        check_reg("pre_r2", 5'd2, 32'd3);

        // ADD r4 = r1 + r2
        issue(ALU_ADD, 5'd1, 5'd2, 5'd4);
        check_val("add_op1", OP_1, 32'd5);
        check_val("add_op2", OP_2, 32'd3);
        check_val("add_sel", 32'(ALU_Sel), 32'(ALU_ADD));
        @(negedge CLK);
        check_val("add_done", 32'(u_bus.DONE), 32'd1);
        check_reg("add_r4_not_yet", 5'd4, 32'd0);
        @(negedge CLK);
        check_val("add_done_clr", 32'(u_bus.DONE),        32'd0);
        check_val("add_rdy_idle", 32'(u_bus.INSTR_READY), 32'd1);
        check_reg("add_r4", 5'd4, 32'd8);

        // Back-to-back SUB r5 = r4 - r2 reads the fresh r4
        issue(ALU_SUB, 5'd4, 5'd2, 5'd5);
        check_val("sub_op1_raw", OP_1, 32'd8);
        wb_phase("sub", 1'b0, 5'd0, 32'd0);
        check_reg("sub_r5", 5'd5, 32'd5);
        check_val("idle_op1_held", OP_1, 32'd8);
        check_val("idle_sel_held", 32'(ALU_Sel), 32'(ALU_SUB));

        issue(ALU_GT, 5'd1, 5'd2, 5'd6);
        wb_phase("gt", 1'b0, 5'd0, 32'd0);
        check_reg("gt_r6", 5'd6, 32'd1);

        issue(ALU_GT, 5'd2, 5'd1, 5'd7);
        wb_phase("gt_sw", 1'b0, 5'd0, 32'd0);
        check_reg("gt_sw_r7", 5'd7, 32'd0);

        issue(3'b111, 5'd1, 5'd2, 5'd8);
        check_val("sel7_pass", 32'(ALU_Sel), 32'd7);
        wb_phase("sel7", 1'b0, 5'd0, 32'd0);
        check_reg("sel7_r8", 5'd8, 32'd0);

        issue(ALU_ADD, 5'd2, 5'd2, 5'd13);
        check_val("same_op1", OP_1, 32'd3);
        check_val("same_op2", OP_2, 32'd3);
        wb_phase("same", 1'b0, 5'd0, 32'd0);
        check_reg("same_r13", 5'd13, 32'd6);

        // WB and EXT on the same address: WB wins
        issue(ALU_ADD, 5'd1, 5'd2, 5'd9);
        wb_phase("clash", 1'b1, 5'd9, 32'hDEAD);
        check_reg("clash_r9", 5'd9, 32'd8);

        issue(ALU_ADD, 5'd1, 5'd2, 5'd10);
        wb_phase("split", 1'b1, 5'd11, 32'hDEAD);
        check_reg("split_r10", 5'd10, 32'd8);
        check_reg("split_r11", 5'd11, 32'hDEAD);

        // Preload in the accept cycle is not seen by that accept
        EXT_WE    = 1'b1;
        EXT_ADDR  = 5'd1;
        EXT_WDATA = 32'd100;
        issue(ALU_ADD, 5'd1, 5'd2, 5'd14);
        EXT_WE = 1'b0;
        check_val("acc_pre_op1", OP_1, 32'd5);
        wb_phase("acc_pre", 1'b0, 5'd0, 32'd0);
        check_reg("acc_pre_r14", 5'd14, 32'd8);
        check_reg("acc_pre_r1",  5'd1,  32'd100);

        // Write-back to register 0
        issue(ALU_ADD, 5'd3, 5'd3, 5'd0);
        wb_phase("r0", 1'b0, 5'd0, 32'd0);
`ifdef R0_ZERO_EN
        check_reg("r0_wb", 5'd0, 32'd0);
`else
        check_reg("r0_wb", 5'd0, 32'd14);
`endif

        // Reset in EXEC aborts the op
        issue(ALU_ADD, 5'd1, 5'd2, 5'd12);
        RST = 1'b1;
        @(negedge CLK);
        check_val("abort_done",  32'(u_bus.DONE),        32'd0);
        check_val("abort_ready", 32'(u_bus.INSTR_READY), 32'd1);
        check_val("abort_op1",   OP_1,                   32'd0);
        check_reg("abort_r12", 5'd12, 32'd0);
        check_reg("abort_r4",  5'd4,  32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check_val("post_rst_done",  32'(u_bus.DONE),        32'd0);
        check_val("post_rst_ready", 32'(u_bus.INSTR_READY), 32'd1);
        check_reg("post_rst_r12", 5'd12, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
